// File: rtl/cu_fsm_intr_if.sv
// ============================================================================
// Module      : cu_fsm_intr_if
// Description : Decode inputs and control outputs of the control-unit FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cu_fsm_intr_if;
    logic       intr;
    logic       csr_mie;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       pc_write;
    logic       reg_write;
    logic       mem_we2;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       pc_rst;
    logic       int_taken;
    logic       csr_we;
    logic       mret_exec;
    logic [1:0] state_o;

    modport master (
        output intr, csr_mie, opcode, func3,
        input  pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
               pc_rst, int_taken, csr_we, mret_exec, state_o
    );

    modport slave (
        input  intr, csr_mie, opcode, func3,
        output pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
               pc_rst, int_taken, csr_we, mret_exec, state_o
    );
endinterface

`default_nettype wire

// File: rtl/cu_fsm_intr.sv
// ============================================================================
// Module      : cu_fsm_intr
// Description : Multicycle CPU control FSM (FETCH/EXEC/WB/INTR) with a
//               synchronised, level-sensitive interrupt input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_fsm_intr #(
    parameter int LOAD_WAIT = 1,
    parameter int INTR_SYNC = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cu_fsm_intr_if.slave  bus
);

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [2:0] c_wait_init = 3'(LOAD_WAIT - 1);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WB    = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_wait;
    logic [INTR_SYNC-1:0]   r_sync;
    logic                   w_pend;
    logic                   w_is_load;
    logic                   w_wb_last;

    generate
        if (INTR_SYNC == 1) begin : g_sync_single
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= bus.intr;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk) begin
                if (rst) r_sync <= '0;
                else     r_sync <= {r_sync[INTR_SYNC-2:0], bus.intr};
            end
        end
    endgenerate

    // Pending is only acted on in an instruction's final cycle; nothing latches it.
    assign w_pend    = r_sync[INTR_SYNC-1] & bus.csr_mie;
    assign w_is_load = (bus.opcode == c_op_load);
    assign w_wb_last = (r_wait == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_wait  <= 3'd0;
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_is_load) begin
                        r_state <= ST_WB;
                        r_wait  <= c_wait_init;
                    end else begin
                        r_state <= w_pend ? ST_INTR : ST_FETCH;
                    end
                end
                ST_WB: begin
                    if (w_wb_last) r_state <= w_pend ? ST_INTR : ST_FETCH;
                    else           r_wait  <= r_wait - 3'd1;
                end
                ST_INTR:  r_state <= ST_FETCH;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    logic       w_pc_write, w_reg_write, w_mem_we2, w_mem_rden1, w_mem_rden2;
    logic       w_pc_rst, w_int_taken, w_csr_we, w_mret_exec;
    logic [1:0] w_state;

    // Reset masks every output (state_o included) so an aborted instruction
    // cannot write anything in the cycle reset is sampled.
    always_comb begin
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_we2   = 1'b0;
        w_mem_rden1 = 1'b0;
        w_mem_rden2 = 1'b0;
        w_pc_rst    = 1'b0;
        w_int_taken = 1'b0;
        w_csr_we    = 1'b0;
        w_mret_exec = 1'b0;
        w_state     = 2'd0;
        if (rst) begin
            w_pc_rst = 1'b1;
        end else begin
            w_state = r_state;
            case (r_state)
                ST_FETCH: w_mem_rden1 = 1'b1;
                ST_EXEC: begin
                    case (bus.opcode)
                        c_op_load:   w_mem_rden2 = 1'b1;
                        c_op_store: begin
                            w_mem_we2  = 1'b1;
                            w_pc_write = 1'b1;
                        end
                        c_op_branch: w_pc_write = 1'b1;
                        c_op_system: begin
                            w_pc_write = 1'b1;
                            if (bus.func3 == 3'b000) begin
                                w_mret_exec = 1'b1;
                            end else begin
                                w_reg_write = 1'b1;
                                w_csr_we    = 1'b1;
                            end
                        end
                        c_op_op, c_op_imm, c_op_lui, c_op_auipc, c_op_jal, c_op_jalr: begin
                            w_pc_write  = 1'b1;
                            w_reg_write = 1'b1;
                        end
                        default:     w_pc_write = 1'b1;
                    endcase
                end
                ST_WB: begin
                    w_pc_write  = w_wb_last;
                    w_reg_write = w_wb_last;
                end
                ST_INTR: begin
                    w_int_taken = 1'b1;
                    w_pc_write  = 1'b1;
                end
                default: w_mem_rden1 = 1'b0;
            endcase
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.reg_write = w_reg_write;
    assign bus.mem_we2   = w_mem_we2;
    assign bus.mem_rden1 = w_mem_rden1;
    assign bus.mem_rden2 = w_mem_rden2;
    assign bus.pc_rst    = w_pc_rst;
    assign bus.int_taken = w_int_taken;
    assign bus.csr_we    = w_csr_we;
    assign bus.mret_exec = w_mret_exec;
    assign bus.state_o   = w_state;

endmodule

`default_nettype wire

// File: tb/tb_cu_fsm_intr.sv
// ============================================================================
// Module      : tb_cu_fsm_intr
// Description : Scoreboard bench for cu_fsm_intr (LOAD_WAIT=3, INTR_SYNC=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cu_fsm_intr;

    localparam int C_LOAD_WAIT = 3;
    localparam int C_INTR_SYNC = 2;

    localparam logic [1:0] C_F = 2'd0, C_E = 2'd1, C_W = 2'd2, C_I = 2'd3;
    // flag bits: pc_write reg_write mem_we2 mem_rden1 mem_rden2 pc_rst int_taken csr_we mret_exec
    localparam logic [8:0] PCW = 9'h100, RW = 9'h080, WE2 = 9'h040, RD1 = 9'h020;
    localparam logic [8:0] RD2 = 9'h010, PRST = 9'h008, INT = 9'h004, CSRW = 9'h002, MRET = 9'h001;
    localparam logic [8:0] NONE = 9'h000;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_SYS = 7'b1110011, OP_OP = 7'b0110011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_FENCE = 7'b0001111;

    typedef struct {
        logic [10:0] exp;
        string       name;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  g_rst = 1'b1, g_intr = 1'b0, g_mie = 1'b0;
    item_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    cu_fsm_intr_if bus ();

    cu_fsm_intr #(
        .LOAD_WAIT (C_LOAD_WAIT),
        .INTR_SYNC (C_INTR_SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle is an output beat; compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            item_t it;
            logic [10:0] act;
            it  = sb_q.pop_front();
            act = {bus.state_o, bus.pc_write, bus.reg_write, bus.mem_we2, bus.mem_rden1,
                   bus.mem_rden2, bus.pc_rst, bus.int_taken, bus.csr_we, bus.mret_exec};
            n_checks++;
            if (act !== it.exp) begin
                n_errors++;
                $display("FAIL %s: got state=%0d flags=%b, expected state=%0d flags=%b",
                         it.name, act[10:9], act[8:0], it.exp[10:9], it.exp[8:0]);
            end
        end
    end

    task automatic cyc(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [1:0] st, input logic [8:0] fl);
        item_t it;
        @(posedge clk);
        #1;
        rst         = g_rst;
        bus.intr    = g_intr;
        bus.csr_mie = g_mie;
        bus.opcode  = op;
        bus.func3   = f3;
        it.exp  = {st, fl};
        it.name = nm;
        sb_q.push_back(it);
    endtask

    task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [8:0] fl);
        cyc({nm, "_fetch"}, op, f3, C_F, RD1);
        cyc({nm, "_exec"},  op, f3, C_E, fl);
    endtask

    task automatic load(input string nm);
        cyc({nm, "_fetch"}, OP_LOAD, 3'b010, C_F, RD1);
        cyc({nm, "_exec"},  OP_LOAD, 3'b010, C_E, RD2);
        cyc({nm, "_wb0"},   OP_LOAD, 3'b010, C_W, NONE);
        cyc({nm, "_wb1"},   OP_LOAD, 3'b010, C_W, NONE);
        cyc({nm, "_wb2"},   OP_LOAD, 3'b010, C_W, PCW | RW);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.intr = 1'b0; bus.csr_mie = 1'b0; bus.opcode = 7'd0; bus.func3 = 3'd0;
        repeat (2) @(posedge clk);
        cyc("rst0", OP_IMM, 3'd0, C_F, PRST);
        cyc("rst1", OP_IMM, 3'd0, C_F, PRST);
        g_rst = 1'b0;

        instr("addi", OP_IMM, 3'd0, PCW | RW);
        load("lw");
        instr("sw",     OP_STORE, 3'b010, WE2 | PCW);
        instr("beq",    OP_BR,    3'b000, PCW);
        instr("csrrw",  OP_SYS,   3'b001, PCW | RW | CSRW);
        instr("csrrs",  OP_SYS,   3'b010, PCW | RW | CSRW);
        instr("fence",  OP_FENCE, 3'b000, PCW);
        instr("lui",    OP_LUI,   3'b000, PCW | RW);
        instr("auipc",  OP_AUIPC, 3'b000, PCW | RW);
        instr("jal",    OP_JAL,   3'b000, PCW | RW);
        instr("jalr",   OP_JALR,  3'b000, PCW | RW);
        instr("add",    OP_OP,    3'b000, PCW | RW);
        instr("mret_q", OP_SYS,   3'b000, PCW | MRET);

        // Interrupt raised in the EXEC of an ADDI reaches the last sync stage in the SW's EXEC.
        cyc("pre_fetch", OP_IMM, 3'd0, C_F, RD1);
        g_intr = 1'b1; g_mie = 1'b1;
        cyc("pre_exec", OP_IMM, 3'd0, C_E, PCW | RW);
        instr("sw_int", OP_STORE, 3'b010, WE2 | PCW);
        g_mie = 1'b0;
        cyc("sw_intr", OP_IMM, 3'd0, C_I, PCW | INT);

        for (int i = 0; i < 10; i++) instr($sformatf("nomie%0d", i), OP_IMM, 3'd0, PCW | RW);

        g_mie = 1'b1;
        instr("mret_int", OP_SYS, 3'b000, PCW | MRET);
        g_mie = 1'b0;
        cyc("mret_intr", OP_IMM, 3'd0, C_I, PCW | INT);

        // Drop intr, let the chain drain, then enable: no interrupt must follow.
        g_intr = 1'b0;
        instr("drain", OP_IMM, 3'd0, PCW | RW);
        g_mie = 1'b1;
        instr("nolatch", OP_IMM, 3'd0, PCW | RW);

        // One-cycle pulse reaches the last stage only during FETCH.
        g_intr = 1'b1;
        cyc("pulse_fetch", OP_IMM, 3'd0, C_F, RD1);
        g_intr = 1'b0;
        cyc("pulse_exec", OP_IMM, 3'd0, C_E, PCW | RW);
        instr("pulse_next", OP_IMM, 3'd0, PCW | RW);
        instr("pulse_after", OP_IMM, 3'd0, PCW | RW);

        g_intr = 1'b1;
        load("lw_int");
        g_mie = 1'b0; g_intr = 1'b0;
        cyc("lw_intr", OP_IMM, 3'd0, C_I, PCW | INT);
        instr("post_lw", OP_IMM, 3'd0, PCW | RW);

        cyc("lwr_fetch", OP_LOAD, 3'b010, C_F, RD1);
        cyc("lwr_exec",  OP_LOAD, 3'b010, C_E, RD2);
        cyc("lwr_wb0",   OP_LOAD, 3'b010, C_W, NONE);
        g_rst = 1'b1;
        cyc("lwr_rst_wb1", OP_LOAD, 3'b010, C_F, PRST);
        cyc("lwr_rst2",    OP_LOAD, 3'b010, C_F, PRST);
        g_rst = 1'b0;
        instr("after_rst", OP_IMM, 3'd0, PCW | RW);

        @(posedge clk);
        #6;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
